// File: rtl/cm0ik_rom_arb_if.sv
// AHB-Lite bundle around the ROM arbiter: two upstream ports (S0, S1) and the ROM-side port (M).
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface cm0ik_rom_arb_if;
  logic        HSELS0;
  logic        HSELS1;
  logic [31:0] HADDRS0;
  logic [31:0] HADDRS1;
  logic [1:0]  HTRANSS0;
  logic [1:0]  HTRANSS1;
  logic        HWRITES0;
  logic        HWRITES1;
  logic        HREADYS0;
  logic        HREADYS1;
  logic [31:0] HRDATAS0;
  logic [31:0] HRDATAS1;
  logic        HREADYOUTS0;
  logic        HREADYOUTS1;
  logic        HRESPS0;
  logic        HRESPS1;

  logic        HSELM;
  logic [31:0] HADDRM;
  logic [1:0]  HTRANSM;
  logic        HREADYM;
  logic [31:0] HRDATAM;
  logic        HREADYOUTM;
  logic        HRESPM;

  modport slave (
    input  HSELS0, HSELS1, HADDRS0, HADDRS1, HTRANSS0, HTRANSS1,
           HWRITES0, HWRITES1, HREADYS0, HREADYS1,
           HRDATAM, HREADYOUTM, HRESPM,
    output HRDATAS0, HRDATAS1, HREADYOUTS0, HREADYOUTS1, HRESPS0, HRESPS1,
           HSELM, HADDRM, HTRANSM, HREADYM
  );

  modport master (
    output HSELS0, HSELS1, HADDRS0, HADDRS1, HTRANSS0, HTRANSS1,
           HWRITES0, HWRITES1, HREADYS0, HREADYS1,
           HRDATAM, HREADYOUTM, HRESPM,
    input  HRDATAS0, HRDATAS1, HREADYOUTS0, HREADYOUTS1, HRESPS0, HRESPS1,
           HSELM, HADDRM, HTRANSM, HREADYM
  );
endinterface

// File: rtl/cm0ik_rom_arb.sv
// Two-port AHB-Lite arbiter in front of the ROM: losing reads are pended and replayed from a register
// (one extra data cycle per winner ahead), writes are answered locally with a two-cycle ERROR.
module cm0ik_rom_arb #(
  parameter int ADDRWIDTH = 32,
  parameter bit PRIORITY  = 1'b0
) (
  input logic            HCLK,
  input logic            HRESETn,
  cm0ik_rom_arb_if.slave bus
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {OWN_NONE, OWN_S0, OWN_S1} own_t;
  typedef enum logic [1:0] {ERR_IDLE, ERR_1, ERR_2} err_t;

  own_t                 dp_own, dp_own_nxt;
  err_t                 err0, err1, err0_nxt, err1_nxt;
  logic                 pend0, pend1, pend0_nxt, pend1_nxt;
  logic [ADDRWIDTH-1:0] pend_addr0, pend_addr1, pend_addr0_nxt, pend_addr1_nxt;
  logic                 last_grant, last_grant_nxt;
  logic [31:0]          haddr_q, haddr_nxt;

  logic                 req0, req1, rd0, rd1, wr0, wr1, eff0, eff1;
  logic                 grant, issue;
  logic [ADDRWIDTH-1:0] addr_sel;
  logic [31:0]          addr_ext;
  logic                 unused_bits;

  assign req0 = bus.HSELS0 & bus.HTRANSS0[1] & bus.HREADYS0;
  assign req1 = bus.HSELS1 & bus.HTRANSS1[1] & bus.HREADYS1;
  assign rd0  = req0 & ~bus.HWRITES0;
  assign rd1  = req1 & ~bus.HWRITES1;
  assign wr0  = req0 & bus.HWRITES0;
  assign wr1  = req1 & bus.HWRITES1;
  assign eff0 = pend0 | rd0;
  assign eff1 = pend1 | rd1;

  assign unused_bits = ^{bus.HTRANSS0[0], bus.HTRANSS1[0], bus.HADDRS0, bus.HADDRS1};

  // grant: 0 = S0, 1 = S1; round-robin picks the port that did not win last
  always_comb begin
    grant = eff1;
    if (eff0 && eff1) begin
      grant = PRIORITY ? 1'b0 : ~last_grant;
    end
  end

  // Reset is folded in so nothing reaches the ROM while the arbiter is held in reset
  assign issue = HRESETn & bus.HREADYOUTM & (eff0 | eff1);

  always_comb begin
    if (grant) begin
      addr_sel = pend1 ? pend_addr1 : bus.HADDRS1[ADDRWIDTH-1:0];
    end else begin
      addr_sel = pend0 ? pend_addr0 : bus.HADDRS0[ADDRWIDTH-1:0];
    end
    addr_ext                  = '0;
    addr_ext[ADDRWIDTH-1:0]   = addr_sel;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_own     <= OWN_NONE;
      err0       <= ERR_IDLE;
      err1       <= ERR_IDLE;
      pend0      <= 1'b0;
      pend1      <= 1'b0;
      pend_addr0 <= '0;
      pend_addr1 <= '0;
      last_grant <= 1'b1;
      haddr_q    <= '0;
    end else begin
      dp_own     <= dp_own_nxt;
      err0       <= err0_nxt;
      err1       <= err1_nxt;
      pend0      <= pend0_nxt;
      pend1      <= pend1_nxt;
      pend_addr0 <= pend_addr0_nxt;
      pend_addr1 <= pend_addr1_nxt;
      last_grant <= last_grant_nxt;
      haddr_q    <= haddr_nxt;
    end
  end

  always_comb begin
    pend0_nxt      = pend0;
    pend1_nxt      = pend1;
    pend_addr0_nxt = pend_addr0;
    pend_addr1_nxt = pend_addr1;
    dp_own_nxt     = dp_own;
    last_grant_nxt = last_grant;
    haddr_nxt      = haddr_q;

    if (issue && !grant) begin
      pend0_nxt = 1'b0;
    end else if (rd0 && !pend0) begin
      pend0_nxt      = 1'b1;
      pend_addr0_nxt = bus.HADDRS0[ADDRWIDTH-1:0];
    end

    if (issue && grant) begin
      pend1_nxt = 1'b0;
    end else if (rd1 && !pend1) begin
      pend1_nxt      = 1'b1;
      pend_addr1_nxt = bus.HADDRS1[ADDRWIDTH-1:0];
    end

    if (bus.HREADYOUTM) begin
      dp_own_nxt = issue ? (grant ? OWN_S1 : OWN_S0) : OWN_NONE;
    end

    if (issue) begin
      last_grant_nxt = grant;
      haddr_nxt      = addr_ext;
    end

    // A new write may land in ERR_2 because the port is ready again there
    case (err0)
      ERR_1:   err0_nxt = ERR_2;
      default: err0_nxt = wr0 ? ERR_1 : ERR_IDLE;
    endcase
    case (err1)
      ERR_1:   err1_nxt = ERR_2;
      default: err1_nxt = wr1 ? ERR_1 : ERR_IDLE;
    endcase
  end

  always_comb begin
    bus.HRDATAS0 = bus.HRDATAM;
    bus.HRDATAS1 = bus.HRDATAM;
    bus.HSELM    = issue;
    bus.HTRANSM  = issue ? TRANS_NONSEQ : TRANS_IDLE;
    bus.HADDRM   = issue ? addr_ext : haddr_q;
    bus.HREADYM  = bus.HREADYOUTM;

    if (dp_own == OWN_S0) begin
      bus.HREADYOUTS0 = bus.HREADYOUTM;
      bus.HRESPS0     = bus.HRESPM;
    end else if (pend0 || err0 == ERR_1) begin
      bus.HREADYOUTS0 = 1'b0;
      bus.HRESPS0     = (err0 == ERR_1);
    end else begin
      bus.HREADYOUTS0 = 1'b1;
      bus.HRESPS0     = (err0 == ERR_2);
    end

    if (dp_own == OWN_S1) begin
      bus.HREADYOUTS1 = bus.HREADYOUTM;
      bus.HRESPS1     = bus.HRESPM;
    end else if (pend1 || err1 == ERR_1) begin
      bus.HREADYOUTS1 = 1'b0;
      bus.HRESPS1     = (err1 == ERR_1);
    end else begin
      bus.HREADYOUTS1 = 1'b1;
      bus.HRESPS1     = (err1 == ERR_2);
    end
  end

endmodule
